// File: rtl/raster_timing.sv
// rtl/raster_timing.sv - dot/phi/position/raster timing generator in the clk_dot4x domain
// Optional raster-compare interrupt built when RASTER_IRQ_EN is defined.
module raster_timing #(
    parameter int CYCLES_PER_LINE = 63,
    parameter int RASTER_LINES    = 312
) (
    input  logic       clk_dot4x,
    input  logic       rst,
    input  logic [8:0] raster_cmp,
    input  logic       irq_ack,
    output logic       dot_rising,
    output logic       clk_phi,
    output logic [9:0] xpos,
    output logic [6:0] cycle_num,
    output logic [8:0] raster_line,
    output logic       frame_start,
    output logic       irq_raster
);

    localparam logic [6:0] LAST_CYCLE = 7'(CYCLES_PER_LINE - 1);
    localparam logic [8:0] LAST_LINE  = 9'(RASTER_LINES - 1);

    logic [1:0] phase;
    logic [2:0] dot;

    logic [2:0] dot_n;
    logic [9:0] xpos_n;
    logic [6:0] cycle_n;
    logic [8:0] line_n;

    // Position the counters move to at the next dot boundary.
    always_comb begin
        dot_n   = dot + 3'd1;
        xpos_n  = xpos + 10'd1;
        cycle_n = cycle_num;
        line_n  = raster_line;
        if (dot == 3'd7) begin
            if (cycle_num == LAST_CYCLE) begin
                cycle_n = 7'd0;
                xpos_n  = 10'd0;
                line_n  = (raster_line == LAST_LINE) ? 9'd0 : raster_line + 9'd1;
            end else begin
                cycle_n = cycle_num + 7'd1;
            end
        end
    end

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            phase       <= 2'd0;
            dot         <= 3'd0;
            dot_rising  <= 1'b0;
            clk_phi     <= 1'b0;
            xpos        <= 10'd0;
            cycle_num   <= 7'd0;
            raster_line <= 9'd0;
            frame_start <= 1'b0;
        end else begin
            phase      <= phase + 2'd1;
            dot_rising <= (phase == 2'd2);
            if (dot_rising) begin
                dot         <= dot_n;
                xpos        <= xpos_n;
                clk_phi     <= dot_n[2];
                cycle_num   <= cycle_n;
                raster_line <= line_n;
                frame_start <= (line_n == 9'd0) && (cycle_n == 7'd0) && (dot_n == 3'd0);
            end
        end
    end

`ifdef RASTER_IRQ_EN
    localparam logic [9:0] NUM_LINES = 10'(RASTER_LINES);

    logic prior_match;
    logic cmp_eq;
    logic irq_set;

    // Line 0 only compares from cycle 1 on, so cycle 0 of line 0 is masked out.
    // A set fires on any rising edge of the equality seen at a dot boundary,
    // which covers both a new line arriving and raster_cmp moving mid-line.
    always_comb begin
        cmp_eq  = !((line_n == 9'd0) && (cycle_n == 7'd0))
                  && ({1'b0, raster_cmp} < NUM_LINES)
                  && (line_n == raster_cmp);
        irq_set = dot_rising && cmp_eq && !prior_match;
    end

    always_ff @(posedge clk_dot4x or posedge rst) begin
        if (rst) begin
            prior_match <= 1'b0;
            irq_raster  <= 1'b0;
        end else begin
            if (dot_rising) begin
                prior_match <= cmp_eq;
            end
            if (irq_set) begin
                irq_raster <= 1'b1;
            end else if (irq_ack) begin
                irq_raster <= 1'b0;
            end
        end
    end
`else
    logic unused_irq_inputs;
    assign unused_irq_inputs = ^{raster_cmp, irq_ack};
    assign irq_raster        = 1'b0;
`endif

endmodule
